// File: rtl/control_sequencer_if.sv
// Datapath-facing bundle for control_sequencer: IR/handshake inputs plus every strobe it drives.
// master = sequencer side, slave = datapath/bench side.
interface control_sequencer_if #(
  parameter int unsigned NREGS = 16
);
  logic [31:0]      ir;
  logic             mem_ready;
  logic             stop;
  logic             PCout, Zlowout, Zhighout, MDRout;
  logic             MARin, Zin, PCin, MDRin, IRin, Yin;
  logic             HIin, LOin, IncPC, Read;
  logic [NREGS-1:0] reg_in;
  logic [NREGS-1:0] reg_out;
  logic [4:0]       alu_op;
  logic             run;

  modport master (
    input  ir, mem_ready, stop,
    output PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           HIin, LOin, IncPC, Read, reg_in, reg_out, alu_op, run
  );

  modport slave (
    output ir, mem_ready, stop,
    input  PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           HIin, LOin, IncPC, Read, reg_in, reg_out, alu_op, run
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps fetch (T0-T2) and execute (T3-T6) and drives all datapath
// strobes as a Moore function of the registered state and the current IR.
// Optional feature: define MULDIV_EN to enable mul/div (HI/LO destination) sequencing;
// otherwise mul/div decode as nop and HIin/LOin/Zhighout stay 0.
module control_sequencer #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned OPC_W = 5
) (
  input logic                 clock,
  input logic                 clear,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
  } state_t;

  localparam logic [NREGS-1:0] OneHot = NREGS'(1);

  state_t             state_q, state_d;
  logic               stop_q, stop_d;
  logic [OPC_W-1:0]   opcode;
  logic [3:0]         ra, rb, rc;
  logic               is_alu3, is_unary, is_muldiv, is_halt, end_to_halt;
  logic               unused_ir;

  assign opcode    = bus.ir[31 -: OPC_W];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign unused_ir = ^bus.ir[14:0];

  // Opcode classification; anything not recognised falls through as nop
  always_comb begin
    is_alu3   = (opcode >= OPC_W'(5'b00011)) && (opcode <= OPC_W'(5'b01010));
    is_unary  = (opcode == OPC_W'(5'b10001)) || (opcode == OPC_W'(5'b10010));
    is_halt   = (opcode == OPC_W'(5'b11011));
`ifdef MULDIV_EN
    is_muldiv = (opcode == OPC_W'(5'b01111)) || (opcode == OPC_W'(5'b10000));
`else
    is_muldiv = 1'b0;
`endif
  end

  // State and latched stop request
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= StRst;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
    end
  end

  // Next-state decode and Moore strobe outputs
  always_comb begin
    state_d      = state_q;
    stop_d       = stop_q;
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.MDRout   = 1'b0;
    bus.MARin    = 1'b0;
    bus.Zin      = 1'b0;
    bus.PCin     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.reg_in   = '0;
    bus.reg_out  = '0;
    bus.alu_op   = '0;
    bus.run      = (state_q != StRst) && (state_q != StHalt);
    // A stop seen anywhere in the instruction is held until the boundary
    end_to_halt  = stop_q || bus.stop;
    if (bus.run && bus.stop) stop_d = 1'b1;

    unique case (state_q)
      StRst: state_d = StT0;
      StT0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        state_d   = StT1;
      end
      StT1: begin
        // Z still holds PC+1 on wait cycles, so repeating PCin is harmless
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        if (bus.mem_ready) state_d = StT2;
      end
      StT2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        if (is_halt)                            state_d = StHalt;
        else if (is_alu3 || is_unary || is_muldiv) state_d = StT3;
        else                                    state_d = end_to_halt ? StHalt : StT0;
      end
      StT3: begin
        bus.alu_op = 5'(opcode);
        if (is_muldiv) begin
          bus.reg_out = OneHot << ra;
          bus.Yin     = 1'b1;
        end else if (is_unary) begin
          bus.reg_out = OneHot << rb;
          bus.Zin     = 1'b1;
        end else begin
          bus.reg_out = OneHot << rb;
          bus.Yin     = 1'b1;
        end
        state_d = StT4;
      end
      StT4: begin
        bus.alu_op = 5'(opcode);
        if (is_muldiv) begin
          bus.reg_out = OneHot << rb;
          bus.Zin     = 1'b1;
          state_d     = StT5;
        end else if (is_unary) begin
          bus.Zlowout = 1'b1;
          bus.reg_in  = OneHot << ra;
          state_d     = end_to_halt ? StHalt : StT0;
        end else begin
          bus.reg_out = OneHot << rc;
          bus.Zin     = 1'b1;
          state_d     = StT5;
        end
      end
      StT5: begin
        bus.alu_op  = 5'(opcode);
        bus.Zlowout = 1'b1;
        if (is_muldiv) begin
          bus.LOin = 1'b1;
          state_d  = StT6;
        end else begin
          bus.reg_in = OneHot << ra;
          state_d    = end_to_halt ? StHalt : StT0;
        end
      end
      StT6: begin
        bus.alu_op = 5'(opcode);
`ifdef MULDIV_EN
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
`endif
        state_d = end_to_halt ? StHalt : StT0;
      end
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
    if (state_d == StHalt) stop_d = 1'b0;
  end

endmodule
